sc_mips: RTL and testbench

- Top-level I/O subsystem of the single-cycle MIPS board platform.
- Receives two 8-bit operands over a UART (8N1) and computes their GCD by repeated subtraction.
- Shows the result on 8 LEDs and four 7-segment digits, and sends it back over UART.
- Sits directly on board pins: sysclk, reset, switches, LEDs, UART, displays.

---
 rtl/sc_mips.sv | 253 +++++++++++++++++++++++++
 tb/tb_sc_mips.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_mips.sv
// Board I/O subsystem: UART-received operand pair -> GCD by subtraction -> LEDs, 7-seg, UART echo-back.
// Optional macro SC_MIPS_ECHO_EN echoes each accepted operand byte before the result.
module sc_mips #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       sysclk,
  input  logic       Reset_n,
  input  logic [7:0] switch,
  input  logic       UART_IN,
  output logic       UART_OUT,
  output logic [7:0] led,
  output logic [6:0] digi_out1,
  output logic [6:0] digi_out2,
  output logic [6:0] digi_out3,
  output logic [6:0] digi_out4
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] U_IDLE = 2'd0, U_START = 2'd1, U_DATA = 2'd2, U_STOP = 2'd3;
  localparam logic [1:0] WAIT_A = 2'd0, WAIT_B = 2'd1, CALC = 2'd2, SEND = 2'd3;

  logic          rx_meta_q, rx_sync_q;
  logic [1:0]    rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;

  logic [1:0]    tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          tx_out_q, tx_out_d;
  logic          tx_idle, tx_req, send_go;
  logic [7:0]    tx_data;

  logic [1:0]    ct_q, ct_d;
  logic [7:0]    a_q, a_d, b_q, b_d, a_org_q, a_org_d, b_org_q, b_org_d;
  logic [7:0]    res_q, res_d, led_q, led_d;

  logic unused_sw;
  assign unused_sw = ^switch[7:1];

  // Receiver: false-start check at half bit, then samples every bit centre
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    case (rx_st_q)
      U_IDLE: if (!rx_sync_q) begin
        rx_st_d  = U_START;
        rx_cnt_d = '0;
      end
      U_START: if (rx_cnt_q == CNT_HALF) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rx_sync_q ? U_IDLE : U_DATA;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      U_DATA: if (rx_cnt_q == CNT_FULL) begin
        rx_cnt_d  = '0;
        rx_byte_d = {rx_sync_q, rx_byte_q[7:1]};
        if (rx_bit_q == 3'd7) rx_st_d = U_STOP;
        else rx_bit_d = rx_bit_q + 1'b1;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
      default: if (rx_cnt_q == CNT_FULL) begin
        rx_cnt_d   = '0;
        rx_st_d    = U_IDLE;
        rx_valid_d = rx_sync_q;
      end else rx_cnt_d = rx_cnt_q + 1'b1;
    endcase
  end

  assign tx_idle = (tx_st_q == U_IDLE);

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_out_d = tx_out_q;
    case (tx_st_q)
      U_IDLE: if (tx_req) begin
        tx_st_d  = U_START;
        tx_cnt_d = '0;
        tx_sh_d  = tx_data;
        tx_out_d = 1'b0;
      end
      U_START: if (tx_cnt_q == CNT_FULL) begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        tx_st_d  = U_DATA;
        tx_out_d = tx_sh_q[0];
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      U_DATA: if (tx_cnt_q == CNT_FULL) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_st_d  = U_STOP;
          tx_out_d = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
          tx_out_d = tx_sh_q[1];
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        end
      end else tx_cnt_d = tx_cnt_q + 1'b1;
      default: if (tx_cnt_q == CNT_FULL) begin
        tx_cnt_d = '0;
        tx_st_d  = U_IDLE;
      end else tx_cnt_d = tx_cnt_q + 1'b1;
    endcase
  end

`ifdef SC_MIPS_ECHO_EN
  logic       echo_pend_q, echo_pend_d;
  logic [7:0] echo_byte_q, echo_byte_d;
  logic       echo_new;
  assign echo_new = rx_valid_q && (ct_q == WAIT_A || ct_q == WAIT_B);
  // A byte arriving while the previous echo is still on the wire is parked until TX frees up
  always_comb begin
    tx_req      = 1'b0;
    tx_data     = res_q;
    echo_pend_d = echo_pend_q;
    echo_byte_d = echo_byte_q;
    if (echo_pend_q) begin
      tx_req  = 1'b1;
      tx_data = echo_byte_q;
      if (tx_idle) echo_pend_d = 1'b0;
    end else if (echo_new) begin
      tx_req  = 1'b1;
      tx_data = rx_byte_q;
      if (!tx_idle) begin
        echo_pend_d = 1'b1;
        echo_byte_d = rx_byte_q;
      end
    end else if (ct_q == SEND) begin
      tx_req = 1'b1;
    end
  end
  assign send_go = (ct_q == SEND) && tx_idle && !echo_pend_q;
  always_ff @(posedge sysclk) begin
    if (Reset_n) begin
      echo_pend_q <= 1'b0;
      echo_byte_q <= '0;
    end else begin
      echo_pend_q <= echo_pend_d;
      echo_byte_q <= echo_byte_d;
    end
  end
`else
  assign tx_req  = (ct_q == SEND);
  assign tx_data = res_q;
  assign send_go = (ct_q == SEND) && tx_idle;
`endif

  always_comb begin
    ct_d    = ct_q;
    a_d     = a_q;
    b_d     = b_q;
    a_org_d = a_org_q;
    b_org_d = b_org_q;
    res_d   = res_q;
    led_d   = led_q;
    case (ct_q)
      WAIT_A: if (rx_valid_q) begin
        a_d     = rx_byte_q;
        a_org_d = rx_byte_q;
        ct_d    = WAIT_B;
      end
      WAIT_B: if (rx_valid_q) begin
        b_d     = rx_byte_q;
        b_org_d = rx_byte_q;
        ct_d    = CALC;
      end
      CALC: if (a_q == '0 || b_q == '0) begin
        res_d = a_q | b_q;
        led_d = a_q | b_q;
        ct_d  = SEND;
      end else if (a_q > b_q) begin
        a_d = a_q - b_q;
      end else if (b_q > a_q) begin
        b_d = b_q - a_q;
      end else begin
        res_d = a_q;
        led_d = a_q;
        ct_d  = SEND;
      end
      default: if (send_go) ct_d = WAIT_A;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (Reset_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_st_q    <= U_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_st_q    <= U_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_out_q   <= 1'b1;
      ct_q       <= WAIT_A;
      a_q        <= '0;
      b_q        <= '0;
      a_org_q    <= '0;
      b_org_q    <= '0;
      res_q      <= '0;
      led_q      <= '0;
    end else begin
      rx_meta_q  <= UART_IN;
      rx_sync_q  <= rx_meta_q;
      rx_st_q    <= rx_st_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      tx_st_q    <= tx_st_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_out_q   <= tx_out_d;
      ct_q       <= ct_d;
      a_q        <= a_d;
      b_q        <= b_d;
      a_org_q    <= a_org_d;
      b_org_q    <= b_org_d;
      res_q      <= res_d;
      led_q      <= led_d;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

  assign UART_OUT  = tx_out_q;
  assign led       = led_q;
  assign digi_out4 = switch[0] ? hex7(4'h0) : hex7(a_org_q[7:4]);
  assign digi_out3 = switch[0] ? hex7(4'h0) : hex7(a_org_q[3:0]);
  assign digi_out2 = switch[0] ? hex7(res_q[7:4]) : hex7(b_org_q[7:4]);
  assign digi_out1 = switch[0] ? hex7(res_q[3:0]) : hex7(b_org_q[3:0]);
endmodule

// File: tb/tb_sc_mips.sv
// Scoreboard bench for sc_mips: expected TX bytes queued at stimulus time, a UART monitor pops and compares.
module tb_sc_mips;
  localparam int unsigned CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic       uin;
  logic       uout;
  logic [7:0] led;
  logic [6:0] d1, d2, d3, d4;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_tx[$];
  bit          mon_ignore = 1'b0;

  always #5 clk = ~clk;

  sc_mips #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk(clk), .Reset_n(rst), .switch(sw), .UART_IN(uin), .UART_OUT(uout),
    .led(led), .digi_out1(d1), .digi_out2(d2), .digi_out3(d3), .digi_out4(d4)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_digits(input string name, input logic [6:0] e4, input logic [6:0] e3,
                              input logic [6:0] e2, input logic [6:0] e1);
    check({name, "_d4"}, {1'b0, d4}, {1'b0, e4});
    check({name, "_d3"}, {1'b0, d3}, {1'b0, e3});
    check({name, "_d2"}, {1'b0, d2}, {1'b0, e2});
    check({name, "_d1"}, {1'b0, d1}, {1'b0, e1});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uin = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uin = b[i];
      repeat (CPB) @(posedge clk);
    end
    uin = stop;
    repeat (CPB) @(posedge clk);
    uin = 1'b1;
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] g);
`ifdef SC_MIPS_ECHO_EN
    exp_tx.push_back(a);
    exp_tx.push_back(b);
`endif
    exp_tx.push_back(g);
  endtask

  task automatic wait_tx(input string name);
    int n = 0;
    while (exp_tx.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (exp_tx.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending bytes expected 0", name, exp_tx.size());
      exp_tx.delete();
    end
    repeat (CPB) @(negedge clk);
  endtask

  // UART monitor: decodes every frame on UART_OUT at bit centres
  initial begin
    logic [7:0] got;
    logic       stopb;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (!rst && uout === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          got[i] = uout;
        end
        repeat (CPB) @(negedge clk);
        stopb = uout;
        if (!mon_ignore) begin
          checks++;
          if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: got %h with no byte expected", got);
          end else begin
            exp = exp_tx.pop_front();
            if (got !== exp || stopb !== 1'b1) begin
              errors++;
              $display("FAIL tx_byte: got %h stop %b expected %h stop 1", got, stopb, exp);
            end
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    sw  = '0;
    uin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_led", led, 8'h00);
    check("rst_uart", {7'd0, uout}, 8'h01);
    check_digits("rst", 7'h40, 7'h40, 7'h40, 7'h40);
    sw = 8'h01;
    #1 check_digits("rst_sw1", 7'h40, 7'h40, 7'h40, 7'h40);
    sw = 8'h00;
    rst = 1'b0;
    repeat (4) @(negedge clk);

    push_exp(8'h0C, 8'h08, 8'h04);
    send_byte(8'h0C, 1'b1);
    send_byte(8'h08, 1'b1);
    wait_tx("gcd_0c_08");
    check("led_0c_08", led, 8'h04);
    check_digits("ops_0c_08", 7'h40, 7'h46, 7'h40, 7'h00);
    sw = 8'h01;
    #1 check_digits("res_0c_08", 7'h40, 7'h40, 7'h40, 7'h19);
    sw = 8'hFE;
    #1 check_digits("sw_hi_ignored", 7'h40, 7'h46, 7'h40, 7'h00);
    sw = 8'h00;

    push_exp(8'h00, 8'h05, 8'h05);
    send_byte(8'h00, 1'b1);
    send_byte(8'h05, 1'b1);
    wait_tx("gcd_00_05");
    check("led_00_05", led, 8'h05);

    push_exp(8'h00, 8'h00, 8'h00);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_tx("gcd_00_00");
    check("led_00_00", led, 8'h00);

    push_exp(8'hFF, 8'hFF, 8'hFF);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    @(negedge clk);
    check("led_ff_ff_fast", led, 8'hFF);
    wait_tx("gcd_ff_ff");

    push_exp(8'hFF, 8'h01, 8'h01);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b1);
    n = 0;
    while (led !== 8'h01 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < 235 || n > 265) begin
      errors++;
      $display("FAIL calc_latency_ff_01: got %0d cycles expected 235..265", n);
    end
    check("led_ff_01", led, 8'h01);
    wait_tx("gcd_ff_01");

    send_byte(8'h5A, 1'b0);
    repeat (2 * CPB) @(posedge clk);
    push_exp(8'h09, 8'h06, 8'h03);
    send_byte(8'h09, 1'b1);
    send_byte(8'h06, 1'b1);
    wait_tx("gcd_after_frame_err");
    check("led_09_06", led, 8'h03);
    check_digits("ops_09_06", 7'h40, 7'h10, 7'h40, 7'h02);

    uin = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    uin = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    push_exp(8'h0A, 8'h0F, 8'h05);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h0F, 1'b1);
    wait_tx("gcd_after_glitch");
    check("led_0a_0f", led, 8'h05);
    check_digits("ops_0a_0f", 7'h40, 7'h08, 7'h40, 7'h0E);

    mon_ignore = 1'b1;
    send_byte(8'h30, 1'b1);
    send_byte(8'h10, 1'b1);
    n = 0;
    while (uout !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (uout !== 1'b0) begin
      errors++;
      $display("FAIL tx_start_timeout: got uart %b expected 0", uout);
    end
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midtx_rst_uart", {7'd0, uout}, 8'h01);
    check("midtx_rst_led", led, 8'h00);
    check_digits("midtx_rst", 7'h40, 7'h40, 7'h40, 7'h40);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
